// File: rtl/ac97_pkg.sv
// Shared definitions for the AC97 frame-content scheduler: scheduler states,
// tag bit positions, slot word formatting and the codec power-up ROM.
package ac97_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_READY = 2'd0,
        ST_INIT       = 2'd1,
        ST_RUN        = 2'd2
    } state_t;

    localparam int SLOT_W = 20;

    // Tag word layout: frame valid, then slot1..slot4 valid, low bits zero.
    localparam int TAG_FRAME = 15;
    localparam int TAG_SLOT1 = 14;
    localparam int TAG_SLOT2 = 13;
    localparam int TAG_SLOT3 = 12;
    localparam int TAG_SLOT4 = 11;

    // Power-up frames carry a command only: frame, slot1 and slot2 valid.
    localparam logic [15:0] TAG_INIT = 16'hE000;

    // Slot1 bit 19 selects read (1) or write (0); the scheduler only writes.
    localparam logic CMD_WRITE = 1'b0;

    // Codec register addresses touched by the power-up sequence.
    localparam logic [6:0] REG_MASTER_VOL  = 7'h02;
    localparam logic [6:0] REG_HP_VOL      = 7'h04;
    localparam logic [6:0] REG_PCM_OUT_VOL = 7'h18;

    localparam int INIT_COUNT = 3;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } cmd_t;

    // Power-up register writes, issued one per frame in index order.
    function automatic cmd_t init_rom(input logic [1:0] idx);
        cmd_t c;
        c = '0;
        case (idx)
            2'd0: begin c.addr = REG_MASTER_VOL;  c.data = 16'h0000; end
            2'd1: begin c.addr = REG_HP_VOL;      c.data = 16'h0000; end
            2'd2: begin c.addr = REG_PCM_OUT_VOL; c.data = 16'h0808; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [SLOT_W-1:0] slot1_word(input logic [6:0] addr);
        return {CMD_WRITE, addr, 12'h000};
    endfunction

    function automatic logic [SLOT_W-1:0] slot2_word(input logic [15:0] data);
        return {data, 4'h0};
    endfunction

endpackage

// File: rtl/ac97_cmd_queue.sv
// Holding stage for host register writes between acceptance and emission.
// AC97_CMD_FIFO_EN defined: 4-entry in-order FIFO.
// AC97_CMD_FIFO_EN undefined: single holding register.
// Pops happen only on frame boundaries chosen by the scheduler.
module ac97_cmd_queue
    import ac97_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        push_valid,
    input  logic [6:0]  push_addr,
    input  logic [15:0] push_data,
    input  logic        pop,
    output logic [6:0]  head_addr,
    output logic [15:0] head_data,
    output logic        full,
    output logic        empty,
    output logic        full_next
);

    cmd_t push_cmd;
    cmd_t head;
    logic push_en;
    logic pop_en;

    assign push_cmd  = {push_addr, push_data};
    assign head_addr = head.addr;
    assign head_data = head.data;

`ifdef AC97_CMD_FIFO_EN
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [2:0]       count_reg;
    logic [2:0]       count_next;
    cmd_t             mem_reg [DEPTH];

    assign push_en = push_valid && (count_reg != 3'd4);
    assign pop_en  = pop && (count_reg != 3'd0);

    // Occupancy after this cycle; a simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push_en, pop_en})
            2'b10:   count_next = count_reg + 3'd1;
            2'b01:   count_next = count_reg - 3'd1;
            default: count_next = count_reg;
        endcase
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_en)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Capture a pushed command into the entry the write pointer selects.
            always_ff @(posedge clk) begin
                if (push_en && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= push_cmd;
                end
            end
        end
    endgenerate

    assign head      = mem_reg[rd_ptr_reg];
    assign full      = (count_reg == 3'd4);
    assign empty     = (count_reg == 3'd0);
    assign full_next = (count_next == 3'd4);
`else
    logic valid_reg;
    logic valid_next;
    cmd_t hold_reg;

    assign push_en = push_valid && !valid_reg;
    assign pop_en  = pop && valid_reg;

    // Register is occupied from acceptance until the frame that emits it.
    always_comb begin
        valid_next = valid_reg;
        if (pop_en)  valid_next = 1'b0;
        if (push_en) valid_next = 1'b1;
    end

    // Single holding register and its occupied flag.
    always_ff @(posedge clk) begin
        if (srst) begin
            valid_reg <= 1'b0;
            hold_reg  <= '0;
        end else begin
            valid_reg <= valid_next;
            if (push_en) hold_reg <= push_cmd;
        end
    end

    assign head      = hold_reg;
    assign full      = valid_reg;
    assign empty     = !valid_reg;
    assign full_next = valid_next;
`endif

endmodule

// File: rtl/ac97_slot_scheduler.sv
// AC97 frame-content scheduler. On each frame_start it loads the tag and
// slot1..slot4 words for the next outgoing frame: nothing while waiting for
// the codec, a fixed power-up register sequence, then host commands and PCM.
// Command holding depth is selected by AC97_CMD_FIFO_EN (see ac97_cmd_queue).
module ac97_slot_scheduler
    import ac97_pkg::*;
#(
    parameter int READY_TIMEOUT = 1024,
    parameter int PCM_W         = 20
) (
    input  logic             clock,
    input  logic             rstbt,
    input  logic             frame_start,
    input  logic             codec_ready,
    input  logic             wr_valid,
    input  logic [6:0]       wr_addr,
    input  logic [15:0]      wr_data,
    output logic             wr_ready,
    input  logic             pcm_valid,
    input  logic [PCM_W-1:0] pcm_left,
    input  logic [PCM_W-1:0] pcm_right,
    output logic             pcm_ready,
    output logic [15:0]      tag,
    output logic [19:0]      slot1,
    output logic [19:0]      slot2,
    output logic [19:0]      slot3,
    output logic [19:0]      slot4,
    output logic [1:0]       state,
    output logic             ready_err,
    output logic [7:0]       underrun_cnt
);

    localparam int CNT_W = $clog2(READY_TIMEOUT + 1);

    state_t              state_reg;
    logic [CNT_W-1:0]    frame_cnt_reg;
    logic [1:0]          init_idx_reg;
    logic [15:0]         tag_reg;
    logic [SLOT_W-1:0]   slot1_reg;
    logic [SLOT_W-1:0]   slot2_reg;
    logic [SLOT_W-1:0]   slot3_reg;
    logic [SLOT_W-1:0]   slot4_reg;
    logic                ready_err_reg;
    logic [7:0]          underrun_reg;
    logic                wr_ready_reg;

    logic                q_pop;
    logic                q_full;
    logic                q_empty;
    logic                q_full_next;
    logic [6:0]          q_head_addr;
    logic [15:0]         q_head_data;

    cmd_t                init_cmd;
    logic [15:0]         run_tag;
    logic [SLOT_W-1:0]   pcm_left_slot;
    logic [SLOT_W-1:0]   pcm_right_slot;
    logic                run_next;

    ac97_cmd_queue u_cmd_queue (
        .clk        (clock),
        .srst       (rstbt),
        .push_valid (wr_valid && wr_ready_reg),
        .push_addr  (wr_addr),
        .push_data  (wr_data),
        .pop        (q_pop),
        .head_addr  (q_head_addr),
        .head_data  (q_head_data),
        .full       (q_full),
        .empty      (q_empty),
        .full_next  (q_full_next)
    );

    // One command per RUN frame; a write accepted on this very edge is not yet visible.
    assign q_pop     = frame_start && (state_reg == ST_RUN) && !q_empty;
    assign pcm_ready = frame_start && (state_reg == ST_RUN) && pcm_valid;
    assign init_cmd  = init_rom(init_idx_reg);

    // Samples sit MSB-aligned in the 20-bit slot with zero padding below.
    always_comb begin
        pcm_left_slot                       = '0;
        pcm_right_slot                      = '0;
        pcm_left_slot[SLOT_W-1 -: PCM_W]    = pcm_left;
        pcm_right_slot[SLOT_W-1 -: PCM_W]   = pcm_right;
    end

    // Tag for a RUN frame from what is available at this boundary.
    always_comb begin
        run_tag            = '0;
        run_tag[TAG_FRAME] = 1'b1;
        run_tag[TAG_SLOT1] = !q_empty;
        run_tag[TAG_SLOT2] = !q_empty;
        run_tag[TAG_SLOT3] = pcm_valid;
        run_tag[TAG_SLOT4] = pcm_valid;
    end

    // True when the state after this edge is RUN, so wr_ready tracks it with no lag.
    assign run_next = (state_reg == ST_RUN) ||
                      ((state_reg == ST_INIT) && frame_start && codec_ready &&
                       (init_idx_reg == 2'(INIT_COUNT - 1)));

    // Registered write-accept flag: open in RUN whenever the holding stage has room.
    always_ff @(posedge clock) begin
        if (rstbt) begin
            wr_ready_reg <= 1'b0;
        end else begin
            wr_ready_reg <= run_next && !q_full_next;
        end
    end

    // Scheduler FSM; all frame outputs load only on frame_start.
    always_ff @(posedge clock) begin
        if (rstbt) begin
            state_reg     <= ST_WAIT_READY;
            frame_cnt_reg <= '0;
            init_idx_reg  <= '0;
            tag_reg       <= '0;
            slot1_reg     <= '0;
            slot2_reg     <= '0;
            slot3_reg     <= '0;
            slot4_reg     <= '0;
            ready_err_reg <= 1'b0;
            underrun_reg  <= '0;
        end else if (frame_start) begin
            case (state_reg)
                ST_WAIT_READY: begin
                    tag_reg   <= '0;
                    slot1_reg <= '0;
                    slot2_reg <= '0;
                    slot3_reg <= '0;
                    slot4_reg <= '0;
                    if (codec_ready) begin
                        state_reg     <= ST_INIT;
                        init_idx_reg  <= '0;
                        frame_cnt_reg <= '0;
                    end else begin
                        if (frame_cnt_reg != CNT_W'(READY_TIMEOUT)) begin
                            frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
                        end
                        // Flag on the frame that brings the count to the timeout.
                        if (frame_cnt_reg >= CNT_W'(READY_TIMEOUT - 1)) begin
                            ready_err_reg <= 1'b1;
                        end
                    end
                end
                ST_INIT: begin
                    if (!codec_ready) begin
                        state_reg    <= ST_WAIT_READY;
                        init_idx_reg <= '0;
                        tag_reg      <= '0;
                        slot1_reg    <= '0;
                        slot2_reg    <= '0;
                    end else begin
                        tag_reg   <= TAG_INIT;
                        slot1_reg <= slot1_word(init_cmd.addr);
                        slot2_reg <= slot2_word(init_cmd.data);
                        if (init_idx_reg == 2'(INIT_COUNT - 1)) begin
                            state_reg    <= ST_RUN;
                            init_idx_reg <= '0;
                        end else begin
                            init_idx_reg <= init_idx_reg + 2'd1;
                        end
                    end
                    slot3_reg <= '0;
                    slot4_reg <= '0;
                end
                ST_RUN: begin
                    tag_reg <= run_tag;
                    if (!q_empty) begin
                        slot1_reg <= slot1_word(q_head_addr);
                        slot2_reg <= slot2_word(q_head_data);
                    end else begin
                        slot1_reg <= '0;
                        slot2_reg <= '0;
                    end
                    if (pcm_valid) begin
                        slot3_reg <= pcm_left_slot;
                        slot4_reg <= pcm_right_slot;
                    end else begin
                        slot3_reg <= '0;
                        slot4_reg <= '0;
                        if (underrun_reg != 8'hFF) underrun_reg <= underrun_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= ST_WAIT_READY;
                    tag_reg   <= '0;
                    slot1_reg <= '0;
                    slot2_reg <= '0;
                    slot3_reg <= '0;
                    slot4_reg <= '0;
                end
            endcase
        end
    end

    assign wr_ready     = wr_ready_reg;
    assign tag          = tag_reg;
    assign slot1        = slot1_reg;
    assign slot2        = slot2_reg;
    assign slot3        = slot3_reg;
    assign slot4        = slot4_reg;
    assign state        = state_reg;
    assign ready_err    = ready_err_reg;
    assign underrun_cnt = underrun_reg;

endmodule

// File: tb/tb_ac97_slot_scheduler.sv
// Scoreboard bench for ac97_slot_scheduler: each frame's expected content is
// queued before the frame is pulsed; a monitor pops and compares on every
// frame_start edge. Handles both AC97_CMD_FIFO_EN settings.
module tb_ac97_slot_scheduler;

    localparam int FRAME = 8;

    logic        clock = 1'b0;
    logic        rstbt = 1'b1;
    logic        frame_start = 1'b0;
    logic        codec_ready = 1'b0;
    logic        wr_valid = 1'b0;
    logic [6:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ready;
    logic        pcm_valid = 1'b1;
    logic [19:0] pcm_left = 20'h12345;
    logic [19:0] pcm_right = 20'hABCDE;
    logic        pcm_ready;
    logic [15:0] tag;
    logic [19:0] slot1, slot2, slot3, slot4;
    logic [1:0]  state;
    logic        ready_err;
    logic [7:0]  underrun_cnt;

    always #5 clock = ~clock;

    ac97_slot_scheduler #(.READY_TIMEOUT(1024), .PCM_W(20)) dut (
        .clock        (clock),
        .rstbt        (rstbt),
        .frame_start  (frame_start),
        .codec_ready  (codec_ready),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .pcm_valid    (pcm_valid),
        .pcm_left     (pcm_left),
        .pcm_right    (pcm_right),
        .pcm_ready    (pcm_ready),
        .tag          (tag),
        .slot1        (slot1),
        .slot2        (slot2),
        .slot3        (slot3),
        .slot4        (slot4),
        .state        (state),
        .ready_err    (ready_err),
        .underrun_cnt (underrun_cnt)
    );

    typedef struct {
        logic [15:0] tag;
        logic [19:0] s1, s2, s3, s4;
        logic [1:0]  st;
        logic        rerr;
        logic [7:0]  ucnt;
        logic        pr;
        logic        wchk;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          fcnt = 0;
    int          m_ucnt = 0;
    logic        m_rerr = 1'b0;
    logic [6:0]  wa [5];
    logic [15:0] wd [5];
    int          acc [5];
    int          acc_exp [5];
    int          base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic void expect_frame(input logic [15:0] t, input logic [19:0] s1, input logic [19:0] s2,
                                         input logic [19:0] s3, input logic [19:0] s4, input logic [1:0] st,
                                         input logic pr, input logic wchk);
        exp_t e;
        e.tag = t; e.s1 = s1; e.s2 = s2; e.s3 = s3; e.s4 = s4; e.st = st;
        e.rerr = m_rerr; e.ucnt = 8'(m_ucnt); e.pr = pr; e.wchk = wchk;
        exp_q.push_back(e);
    endfunction

    task automatic frame();
        @(negedge clock); frame_start = 1'b1; fcnt++;
        @(negedge clock); frame_start = 1'b0;
        repeat (FRAME - 2) @(negedge clock);
    endtask

    task automatic write_seq(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            @(negedge clock); #1;
            wr_valid = 1'b1; wr_addr = wa[i]; wr_data = wd[i];
            t = 0;
            while (!wr_ready && t < 200) begin
                @(negedge clock); #1;
                t++;
            end
            if (t >= 200) begin
                total++; bad++;
                $display("FAIL write%0d: wr_ready never asserted, got 0, expected 1", i);
                acc[i] = -1;
            end else begin
                acc[i] = fcnt;
            end
            @(posedge clock);
        end
        @(negedge clock); #1;
        wr_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, " tag"}, 32'(tag), 32'h0);
        check({pfx, " slot1"}, 32'(slot1), 32'h0);
        check({pfx, " slot2"}, 32'(slot2), 32'h0);
        check({pfx, " slot3"}, 32'(slot3), 32'h0);
        check({pfx, " slot4"}, 32'(slot4), 32'h0);
        check({pfx, " state"}, 32'(state), 32'h0);
        check({pfx, " wr_ready"}, 32'(wr_ready), 32'h0);
        check({pfx, " pcm_ready"}, 32'(pcm_ready), 32'h0);
        check({pfx, " ready_err"}, 32'(ready_err), 32'h0);
        check({pfx, " underrun_cnt"}, 32'(underrun_cnt), 32'h0);
    endtask

    // Monitor: on each frame_start edge pop one expectation and compare.
    initial begin : monitor
        exp_t e;
        logic pr_s;
        logic wr_s;
        forever begin
            @(negedge clock); #2;
            if (frame_start) begin
                pr_s = pcm_ready;
                wr_s = wr_ready;
                @(posedge clock); #1;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL frame%0d: unexpected frame, got 1, expected 0 queued", fcnt);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("frame%0d tag", fcnt), 32'(tag), 32'(e.tag));
                    check($sformatf("frame%0d slot1", fcnt), 32'(slot1), 32'(e.s1));
                    check($sformatf("frame%0d slot2", fcnt), 32'(slot2), 32'(e.s2));
                    check($sformatf("frame%0d slot3", fcnt), 32'(slot3), 32'(e.s3));
                    check($sformatf("frame%0d slot4", fcnt), 32'(slot4), 32'(e.s4));
                    check($sformatf("frame%0d state", fcnt), 32'(state), 32'(e.st));
                    check($sformatf("frame%0d ready_err", fcnt), 32'(ready_err), 32'(e.rerr));
                    check($sformatf("frame%0d underrun_cnt", fcnt), 32'(underrun_cnt), 32'(e.ucnt));
                    check($sformatf("frame%0d pcm_ready", fcnt), 32'(pr_s), 32'(e.pr));
                    if (e.wchk) check($sformatf("frame%0d wr_ready", fcnt), 32'(wr_s), 32'h0);
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset state.
        repeat (3) @(negedge clock);
        #1 check_all_zero("reset");
        @(negedge clock); rstbt = 1'b0;

        // No codec: 1030 empty frames, timeout flag from frame 1024 on.
        for (int i = 1; i <= 1030; i++) begin
            if (i >= 1024) m_rerr = 1'b1;
            expect_frame(16'h0, 20'h0, 20'h0, 20'h0, 20'h0, 2'd0, 1'b0, 1'b1);
            frame();
        end

        // Codec ready: empty frame, then the three power-up writes.
        codec_ready = 1'b1;
        expect_frame(16'h0,    20'h0,     20'h0,     20'h0, 20'h0, 2'd1, 1'b0, 1'b1);
        expect_frame(16'hE000, 20'h02000, 20'h00000, 20'h0, 20'h0, 2'd1, 1'b0, 1'b1);
        expect_frame(16'hE000, 20'h04000, 20'h00000, 20'h0, 20'h0, 2'd1, 1'b0, 1'b1);
        expect_frame(16'hE000, 20'h18000, 20'h08080, 20'h0, 20'h0, 2'd2, 1'b0, 1'b1);
        repeat (4) frame();

        // RUN ignores codec_ready dropping. Write accepted on the frame_start edge.
        codec_ready = 1'b0;
        wa[0] = 7'h10; wd[0] = 16'h1234;
        expect_frame(16'h9800, 20'h0,     20'h0,     20'h12345, 20'hABCDE, 2'd2, 1'b1, 1'b0);
        expect_frame(16'hF800, 20'h10000, 20'h12340, 20'h12345, 20'hABCDE, 2'd2, 1'b1, 1'b0);
        fork
            repeat (2) frame();
            write_seq(1);
        join

        // Mid-frame write: emitted in the next frame only.
        wa[0] = 7'h2C; wd[0] = 16'hBB80;
        expect_frame(16'h9800, 20'h0,     20'h0,     20'h12345, 20'hABCDE, 2'd2, 1'b1, 1'b0);
        expect_frame(16'hF800, 20'h2C000, 20'hBB800, 20'h12345, 20'hABCDE, 2'd2, 1'b1, 1'b0);
        expect_frame(16'h9800, 20'h0,     20'h0,     20'h12345, 20'hABCDE, 2'd2, 1'b1, 1'b0);
        fork
            repeat (3) frame();
            begin repeat (2) @(negedge clock); write_seq(1); end
        join

        // Five back-to-back writes, emitted in order one per frame.
        wa[0] = 7'h2C; wd[0] = 16'h1001;
        wa[1] = 7'h2E; wd[1] = 16'h2002;
        wa[2] = 7'h32; wd[2] = 16'h3003;
        wa[3] = 7'h36; wd[3] = 16'h4004;
        wa[4] = 7'h38; wd[4] = 16'h5005;
        base = fcnt + 1;
        expect_frame(16'h9800, 20'h0,     20'h0,     20'h12345, 20'hABCDE, 2'd2, 1'b1, 1'b0);
        expect_frame(16'hF800, 20'h2C000, 20'h10010, 20'h12345, 20'hABCDE, 2'd2, 1'b1, 1'b0);
        expect_frame(16'hF800, 20'h2E000, 20'h20020, 20'h12345, 20'hABCDE, 2'd2, 1'b1, 1'b0);
        expect_frame(16'hF800, 20'h32000, 20'h30030, 20'h12345, 20'hABCDE, 2'd2, 1'b1, 1'b0);
        expect_frame(16'hF800, 20'h36000, 20'h40040, 20'h12345, 20'hABCDE, 2'd2, 1'b1, 1'b0);
        expect_frame(16'hF800, 20'h38000, 20'h50050, 20'h12345, 20'hABCDE, 2'd2, 1'b1, 1'b0);
        expect_frame(16'h9800, 20'h0,     20'h0,     20'h12345, 20'hABCDE, 2'd2, 1'b1, 1'b0);
        fork
            repeat (7) frame();
            begin repeat (2) @(negedge clock); write_seq(5); end
        join
`ifdef AC97_CMD_FIFO_EN
        acc_exp = '{base, base, base, base, base + 1};
`else
        acc_exp = '{base, base + 1, base + 2, base + 3, base + 4};
`endif
        for (int i = 0; i < 5; i++) begin
            check($sformatf("accept frame write%0d", i), 32'(acc[i]), 32'(acc_exp[i]));
        end

        // PCM underrun for 300 frames: counter saturates at 255.
        pcm_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (m_ucnt < 255) m_ucnt++;
            expect_frame(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0, 2'd2, 1'b0, 1'b0);
            frame();
        end
        check("underrun saturated", 32'(underrun_cnt), 32'd255);

        // Reset, bring up again, and reset in the middle of the power-up sequence.
        pcm_valid = 1'b1;
        @(negedge clock); rstbt = 1'b1;
        @(negedge clock); #1 check_all_zero("reset2");
        rstbt = 1'b0; m_rerr = 1'b0; m_ucnt = 0;
        codec_ready = 1'b1;
        expect_frame(16'h0,    20'h0,     20'h0, 20'h0, 20'h0, 2'd1, 1'b0, 1'b1);
        expect_frame(16'hE000, 20'h02000, 20'h0, 20'h0, 20'h0, 2'd1, 1'b0, 1'b1);
        expect_frame(16'hE000, 20'h04000, 20'h0, 20'h0, 20'h0, 2'd1, 1'b0, 1'b1);
        repeat (3) frame();
        @(negedge clock); rstbt = 1'b1;
        @(negedge clock); #1 check_all_zero("midinit reset");
        rstbt = 1'b0;
        expect_frame(16'h0,    20'h0,     20'h0, 20'h0, 20'h0, 2'd1, 1'b0, 1'b1);
        expect_frame(16'hE000, 20'h02000, 20'h0, 20'h0, 20'h0, 2'd1, 1'b0, 1'b1);
        repeat (2) frame();

        // codec_ready dropping in INIT returns to WAIT_READY and restarts the ROM.
        codec_ready = 1'b0;
        expect_frame(16'h0, 20'h0, 20'h0, 20'h0, 20'h0, 2'd0, 1'b0, 1'b1);
        frame();
        codec_ready = 1'b1;
        expect_frame(16'h0,    20'h0,     20'h0, 20'h0, 20'h0, 2'd1, 1'b0, 1'b1);
        expect_frame(16'hE000, 20'h02000, 20'h0, 20'h0, 20'h0, 2'd1, 1'b0, 1'b1);
        repeat (2) frame();

        repeat (2) @(negedge clock);
        check("expectations consumed", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ac97_slot_scheduler.md
Name: ac97_slot_scheduler

Overview:
- Frame-content scheduler for the AC97 serializer; runs in the codec bit-clock domain.
- On each frame boundary it decides what goes into the next outgoing frame: tag, slot1 command address, slot2 command data, and slot3/slot4 PCM.
- After the codec reports ready, it issues a fixed power-up register sequence, one write per frame.
- In run mode it arbitrates host register writes and the PCM sample stream into their slots.

Parameters:
- READY_TIMEOUT, 1024: frames to wait for codec_ready before flagging ready_err.
- PCM_W, 20: PCM sample width; it fills the 20-bit slot MSB-aligned, zero-padded below.

Ports:
- clock  in  1  codec bit clock; the only clock.
- rstbt  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse from the serializer at bit 255; the next frame's content loads here.
- codec_ready  in  1  codec ready indication (tag bit 15 of the input frame), level.
- wr_valid  in  1  host register-write request.
- wr_addr  in  7  codec register address.
- wr_data  in  16  register write data.
- wr_ready  out  1  host write accepted when wr_valid && wr_ready.
- pcm_valid  in  1  sample pair available.
- pcm_left  in  PCM_W  left sample.
- pcm_right  in  PCM_W  right sample.
- pcm_ready  out  1  sample pair consumed this cycle.
- tag  out  16  slot0 word.
- slot1  out  20  command address word.
- slot2  out  20  command data word.
- slot3  out  20  left PCM word.
- slot4  out  20  right PCM word.
- state  out  2  0=WAIT_READY, 1=INIT, 2=RUN.
- ready_err  out  1  sticky flag: codec_ready timeout.
- underrun_cnt  out  8  saturating count of PCM underrun frames.

Behaviour:
- Reset (rstbt=1 at a clock edge):
  - all outputs are 0 and state=WAIT_READY;
  - the frame counter, init index and holding register/FIFO are cleared;
  - reset applies identically mid-frame or mid-sequence.
- Frame outputs are registered and change only on cycles where frame_start=1; they hold their value otherwise.
- Slot encoding:
  - tag[15] is frame valid;
  - tag[14:11] are the slot1..slot4 valid bits;
  - tag[10:0] are 0;
  - slot1 = {1'b0 (write), addr[6:0], 12'h000};
  - slot2 = {data[15:0], 4'h0}.
- WAIT_READY:
  - frames are emitted all zero, tag=0;
  - wr_ready=0 and pcm_ready=0;
  - a frame counter increments on each frame_start;
  - if codec_ready=1 at a frame_start, go to INIT at that edge;
  - if the counter reaches READY_TIMEOUT, set ready_err (sticky until reset) and keep waiting.
- INIT:
  - at each frame_start, emit the next ROM entry with tag=16'hE000 (frame, slot1, slot2 valid);
  - ROM entries in order: 0x02<=0x0000, 0x04<=0x0000, 0x18<=0x0808;
  - after the third entry is emitted, go to RUN; the next frame_start is the first RUN frame.
  - if codec_ready drops at a frame_start, return to WAIT_READY and restart the ROM index at 0.
- RUN, commands:
  - at most one command per frame;
  - a command is emitted at a frame_start if the holding stage is non-empty; it is then popped and tag[14:13]=2'b11;
  - otherwise slot1=slot2=0 and tag[14:13]=0.
- RUN, write accept:
  - wr_ready = (state==RUN) && holding stage not full, registered;
  - a write accepted in the same cycle as frame_start is not emitted in that frame; it is emitted at the following frame_start earliest;
  - write-to-slot latency is 1 to 2 frames.
- RUN, PCM:
  - pcm_ready = frame_start && state==RUN && pcm_valid, combinational;
  - on that edge slot3/slot4 load the samples and tag[12:11]=2'b11;
  - if pcm_valid=0 at frame_start, slot3=slot4=0, tag[12:11]=0 and underrun_cnt increments, saturating at 255.
- RUN, other rules:
  - tag[15]=1 for every frame in RUN and INIT;
  - codec_ready dropping in RUN does not change state.

Optional Feature:
- Macro: AC97_CMD_FIFO_EN.
- Defined:
  - the holding stage is a 4-entry FIFO of {addr, data};
  - wr_ready=0 only when 4 entries are held;
  - a push and a pop on the same frame_start cycle keep the count unchanged;
  - entries are emitted in order.
- Undefined:
  - the holding stage is a single register;
  - wr_ready deasserts from acceptance until the frame_start that emits it.

Decomposition:
- Shared package ac97_pkg:
  - state enum;
  - tag bit positions;
  - slot width 20;
  - command write/read bit;
  - init ROM entries and count (3);
  - register address constants 0x02, 0x04, 0x18.
- One sub-module, ac97_cmd_queue: the holding register/FIFO with valid/ready push, pop on frame_start, and full/empty outputs.

Test Plan:
- Reset, codec_ready held 0 for 1030 frames -> state=0, tag=0 every frame, ready_err=1 after frame 1024, wr_ready=0 throughout.
- codec_ready=1 at frame_start N -> frames N+1..N+3 show tag=E000 with slot1/slot2 = 02000/00000, 04000/00000, 18000/08080; state=2 after the third.
- In RUN, write addr 0x2C data 0xBB80 mid-frame -> the next frame has slot1=2C000, slot2=BB800, tag[14:13]=11; one frame later slot1=0.
- In RUN, pcm_valid=1 with left=20'h12345, right=20'hABCDE -> pcm_ready pulses with frame_start; slot3/slot4 match; tag=F800 when combined with a command, else 9800. With pcm_valid=0 for 300 frames -> underrun_cnt=255.
- rstbt=1 mid-INIT (after the second ROM write) -> all outputs 0 next cycle; after codec_ready the sequence restarts at 0x02.
- AC97_CMD_FIFO_EN defined, 5 back-to-back writes -> 4 accepted, then wr_ready=0; emitted in order, one per frame. Undefined -> second write stalls until the first is emitted.
